// File: rtl/game_pkg.sv
// Direction codes shared by the move-command front end and the board-update logic.
package game_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_DOWN  = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_RIGHT = 2'b11;

  // Bit order of the button vector is {right, left, down, up}.
  function automatic dir_t onehot_to_dir(input logic [3:0] oh);
    dir_t d;
    d = DIR_UP;
    if (oh[1]) d = DIR_DOWN;
    if (oh[2]) d = DIR_LEFT;
    if (oh[3]) d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Circular command buffer with flush, fill count and sticky overflow flag.
// Head is visible combinationally from registered state, so a pop exposes the next entry with no bubble.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic [1:0]    push_dat,
  input  logic          pop,
  input  logic          flush,
  output logic [1:0]    head_dat,
  output logic          empty,
  output logic [CW-1:0] fill,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] fill_q, fill_d;
  logic          overflow_q, overflow_d;
  logic          full, do_pop, do_push;

  assign empty    = (fill_q == '0);
  assign full     = (fill_q == CW'(DEPTH));
  assign fill     = fill_q;
  assign overflow = overflow_q;
  assign head_dat = empty ? 2'b00 : mem_q[rd_q];

  always_comb begin
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;
    do_pop     = pop && !empty;
    // A full buffer still accepts a push when the head leaves on the same edge.
    do_push    = push && (!full || do_pop);
    if (flush) begin
      rd_d   = wr_q;
      fill_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_dat;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
      fill_d = fill_q + CW'(do_push) - CW'(do_pop);
      if (push && !do_push) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: rtl/move_cmd_queue.sv
// Turns asynchronous button levels into a queue of move commands: sync, press detect, ambiguity reject.
// Held buttons produce one event; simultaneous presses pulse conflict; halt flushes and discards.
module move_cmd_queue
  import game_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          up_in,
  input  logic          down_in,
  input  logic          left_in,
  input  logic          right_in,
  input  logic          halt,
  input  logic          cmd_ready,
  output logic          cmd_valid,
  output logic [1:0]    cmd_dir,
  output logic [CW-1:0] fill,
  output logic          overflow,
  output logic          conflict
);

  logic [3:0] s1_q, s1_d, s2_q, s2_d, p_q, p_d;
  logic       conflict_q, conflict_d;
  logic [3:0] ev;
  logic       multi, push, pop, empty;
  dir_t       push_dir;

  always_comb begin
    s1_d       = {right_in, left_in, down_in, up_in};
    s2_d       = s1_q;
    p_d        = s2_q;
    ev         = s2_q & ~p_q;
    multi      = ((ev & (ev - 4'd1)) != 4'd0);
    push       = (ev != 4'd0) && !multi && !halt;
    push_dir   = onehot_to_dir(ev);
    conflict_d = multi && !halt;
  end

  assign cmd_valid = !empty;
  assign pop       = cmd_valid && cmd_ready;
  assign conflict  = conflict_q;

  // Everything resets to zero, so a button held through reset release reads as a fresh press.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1_q       <= '0;
      s2_q       <= '0;
      p_q        <= '0;
      conflict_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      p_q        <= p_d;
      conflict_q <= conflict_d;
    end
  end

  cmd_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk      (clk),
    .clr      (clr),
    .push     (push),
    .push_dat (push_dir),
    .pop      (pop),
    .flush    (halt),
    .head_dat (cmd_dir),
    .empty    (empty),
    .fill     (fill),
    .overflow (overflow)
  );

endmodule
